// File: rtl/tri_sample_packer_if.sv
// Sample-in / word-out handshake bundle for tri_sample_packer.
// slave: the packer's view. master: the upstream/downstream environment's view.
interface tri_sample_packer_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tri_sample_packer.sv
// tri_sample_packer: packs IN_W-bit {c,b,a} samples LSB-first into OUT_W-bit
// words. A flush zero-pads any partial word and tags the final word out_last.
// Optional build macro TRI_SAMPLE_PACKER_STATS_EN adds word_cnt/stall_cnt.
module tri_sample_packer #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tri_sample_packer_if.slave    bus
`ifdef TRI_SAMPLE_PACKER_STATS_EN
  ,
  output logic [15:0]           word_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int ACC_W  = OUT_W + IN_W - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);

  typedef enum logic {ST_FILL, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [OUT_W-1:0]   pad_mask;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               in_fire;
  logic               out_fire;

  assign in_fire  = bus.in_valid & in_ready_c;
  assign out_fire = out_valid_c & bus.out_ready;

  // State register: accumulator, fill level and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      acc_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
    end
  end

  // Handshake outputs; FLUSH zeroes any word bits at or above the fill level.
  always_comb begin
    pad_mask = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      pad_mask[i] = (i < 32'(fill_q));
    end
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    bus.out_data = acc_q[OUT_W-1:0];
    bus.out_last = 1'b0;
    if (state_q == ST_FILL) begin
      out_valid_c = (fill_q >= FILL_W'(OUT_W));
      in_ready_c  = (fill_q < FILL_W'(OUT_W)) | bus.out_ready;
    end else begin
      out_valid_c  = (fill_q != '0);
      bus.out_data = acc_q[OUT_W-1:0] & pad_mask;
      bus.out_last = (fill_q <= FILL_W'(OUT_W));
    end
    bus.in_ready  = in_ready_c;
    bus.out_valid = out_valid_c;
  end

  // Next state: drain a word first, then append the new sample at the
  // post-drain fill position so sample order is preserved.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    if (state_q == ST_FILL) begin
      if (out_fire) begin
        acc_d  = acc_q >> OUT_W;
        fill_d = fill_q - FILL_W'(OUT_W);
      end
      if (in_fire) begin
        acc_d  = acc_d | (ACC_W'(bus.in_data) << fill_d);
        fill_d = fill_d + FILL_W'(IN_W);
      end
      if (bus.flush && (fill_d != '0)) begin
        state_d = ST_FLUSH;
      end
    end else if (out_fire) begin
      if (fill_q > FILL_W'(OUT_W)) begin
        acc_d  = acc_q >> OUT_W;
        fill_d = fill_q - FILL_W'(OUT_W);
      end else begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = ST_FILL;
      end
    end
  end

`ifdef TRI_SAMPLE_PACKER_STATS_EN
  logic [15:0] word_cnt_q;
  logic [15:0] stall_cnt_q;

  // Free-running wrap-around counters of emitted words and stalled input cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_fire) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (bus.in_valid && !in_ready_c) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
